// File: rtl/sfx_pkg.sv
// -----------------------------------------------------------------------------
// sfx_pkg
// Shared definitions for the sound-effect scheduler:
//   - scheduler state encoding (IDLE / LOAD / PLAY)
//   - effect index constants (move, shoot, hit, game-over)
//   - width constants for half-period, duration and effect id
//   - lookup functions returning the tone half-period (clocks) and the
//     effect duration (ms) for a 2-bit effect id
// -----------------------------------------------------------------------------
package sfx_pkg;

    localparam int unsigned HALF_W  = 18;  // tone half-period width (clocks)
    localparam int unsigned DUR_W   = 10;  // effect duration width (ms)
    localparam int unsigned ID_W    = 2;   // effect index width
    localparam int unsigned NUM_SFX = 4;   // number of effects / pending bits

    localparam logic [ID_W-1:0] SFX_MOVE  = 2'd0;
    localparam logic [ID_W-1:0] SFX_SHOOT = 2'd1;
    localparam logic [ID_W-1:0] SFX_HIT   = 2'd2;
    localparam logic [ID_W-1:0] SFX_OVER  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2
    } state_e;

    // Unscaled tone half-period in system clocks for each effect.
    function automatic logic [HALF_W-1:0] sfx_half(input logic [ID_W-1:0] id);
        logic [HALF_W-1:0] half;
        case (id)
            SFX_MOVE:  half = 18'd50000;
            SFX_SHOOT: half = 18'd25000;
            SFX_HIT:   half = 18'd100000;
            SFX_OVER:  half = 18'd200000;
            default:   half = 18'd50000;
        endcase
        return half;
    endfunction

    // Effect duration in milliseconds for each effect.
    function automatic logic [DUR_W-1:0] sfx_dur(input logic [ID_W-1:0] id);
        logic [DUR_W-1:0] dur;
        case (id)
            SFX_MOVE:  dur = 10'd20;
            SFX_SHOOT: dur = 10'd60;
            SFX_HIT:   dur = 10'd150;
            SFX_OVER:  dur = 10'd600;
            default:   dur = 10'd20;
        endcase
        return dur;
    endfunction

endpackage

// File: rtl/sfx_sched_tone_gen.sv
// -----------------------------------------------------------------------------
// tone_gen
// Reloadable half-period down-counter with a phase toggle. Each half-period
// lasts `half` enabled cycles; a load restarts the tone at phase 0.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   load   in   restart: counter = half-1, phase = 0
//   en     in   count down; at 0 reload half-1 and toggle phase
//   half   in   half-period in clocks (must be >= 1)
//   phase  out  look-ahead phase: the value the phase register takes at the
//               next clock edge. The caller registers it, so its registered
//               copy lines up with the cycle the phase belongs to.
// -----------------------------------------------------------------------------
module tone_gen
    import sfx_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              en,
    input  logic [HALF_W-1:0] half,
    output logic              phase
);

    logic [HALF_W-1:0] cnt_q;
    logic [HALF_W-1:0] cnt_d;
    logic              phase_q;
    logic              phase_d;

    // Next-state logic for the half-period counter and phase.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (load) begin
            cnt_d   = half - HALF_W'(1);
            phase_d = 1'b0;
        end else if (en) begin
            if (cnt_q == '0) begin
                cnt_d   = half - HALF_W'(1);
                phase_d = ~phase_q;
            end else begin
                cnt_d   = cnt_q - HALF_W'(1);
            end
        end else begin
            cnt_d   = cnt_q;
            phase_d = phase_q;
        end
    end

    // Counter and phase registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_d;

endmodule

// File: rtl/sfx_sched.sv
// -----------------------------------------------------------------------------
// sfx_sched
// Shares the single board buzzer between game sound effects. One-cycle
// requests set pending bits; the highest pending effect is loaded and played
// as a square wave for its table duration. A higher-priority pending effect
// preempts the one playing (the preempted effect is dropped, no done pulse).
//
// Parameters:
//   TICK_DIV    clocks per millisecond tick (>= 2)
//   TONE_SHIFT  right shift applied to table half-periods (min result 1)
//
// Ports:
//   clk_100mhz  in   system clock
//   RSTN        in   asynchronous active-low reset
//   sfx_req     in   [3:0] request pulses: 0 move, 1 shoot, 2 hit, 3 game-over
//   mute        in   forces Buzzer to 1 while sequencing continues
//   Buzzer      out  registered active-low buzzer drive (1 = silent)
//   busy        out  1 while in LOAD or PLAY
//   sfx_cur     out  [1:0] effect loaded/playing, holds last value in IDLE
//   sfx_done    out  one-cycle pulse when an effect completes its duration
// -----------------------------------------------------------------------------
module sfx_sched
    import sfx_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 100000,
    parameter int unsigned TONE_SHIFT = 0
) (
    input  logic               clk_100mhz,
    input  logic               RSTN,
    input  logic [NUM_SFX-1:0] sfx_req,
    input  logic               mute,
    output logic               Buzzer,
    output logic               busy,
    output logic [ID_W-1:0]    sfx_cur,
    output logic               sfx_done
);

    localparam int unsigned       TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    // Table half-period scaled down for simulation, never below one clock.
    function automatic logic [HALF_W-1:0] scaled_half(input logic [ID_W-1:0] id);
        logic [HALF_W-1:0] raw;
        raw = sfx_half(id) >> TONE_SHIFT;
        if (raw == '0) begin
            raw = HALF_W'(1);
        end else begin
            raw = raw;
        end
        return raw;
    endfunction

    state_e             state_q,   state_d;
    logic [NUM_SFX-1:0] pending_q, pending_d;
    logic [ID_W-1:0]    cur_q,     cur_d;
    logic [TICK_W-1:0]  tick_q,    tick_d;
    logic [DUR_W-1:0]   dur_q,     dur_d;
    logic               buzzer_q,  buzzer_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;

    logic [NUM_SFX-1:0] clr_s;
    logic [ID_W-1:0]    hi_idx_s;
    logic               hi_any_s;
    logic               tone_load_s;
    logic               tone_en_s;
    logic               tone_phase_s;
    logic [HALF_W-1:0]  tone_half_s;

    // Priority encoder: highest-index pending effect.
    always_comb begin
        hi_any_s = |pending_q;
        if (pending_q[3]) begin
            hi_idx_s = SFX_OVER;
        end else if (pending_q[2]) begin
            hi_idx_s = SFX_HIT;
        end else if (pending_q[1]) begin
            hi_idx_s = SFX_SHOOT;
        end else begin
            hi_idx_s = SFX_MOVE;
        end
    end

    assign tone_half_s = scaled_half(cur_q);

    tone_gen u_tone_gen (
        .clk   (clk_100mhz),
        .rst_n (RSTN),
        .load  (tone_load_s),
        .en    (tone_en_s),
        .half  (tone_half_s),
        .phase (tone_phase_s)
    );

    // Scheduler next-state, counters, pending update and output precompute.
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        tick_d      = tick_q;
        dur_d       = dur_q;
        done_d      = 1'b0;
        clr_s       = '0;
        tone_load_s = 1'b0;
        tone_en_s   = 1'b0;

        case (state_q)
            IDLE: begin
                if (hi_any_s) begin
                    state_d = LOAD;
                    cur_d   = hi_idx_s;
                    clr_s   = 4'b0001 << hi_idx_s;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                tone_load_s = 1'b1;
                tick_d      = '0;
                dur_d       = sfx_dur(cur_q);
                state_d     = PLAY;
            end
            PLAY: begin
                tone_en_s = 1'b1;
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    dur_d  = dur_q - DUR_W'(1);
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
                // Completion of the full duration takes precedence over a
                // preemption seen in the same cycle: the effect did finish.
                if ((tick_q == TICK_LAST) && (dur_q == DUR_W'(1))) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (hi_any_s && (hi_idx_s > cur_q)) begin
                    state_d = LOAD;
                    cur_d   = hi_idx_s;
                    clr_s   = 4'b0001 << hi_idx_s;
                end else begin
                    state_d = PLAY;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new request beats a clear of the same bit.
        pending_d = (pending_q & ~clr_s) | sfx_req;
        busy_d    = (state_d != IDLE);
        // Buzzer is registered, so use the look-ahead phase of the cycle
        // being entered; the first PLAY cycle therefore drives low.
        if (state_d == PLAY) begin
            buzzer_d = mute | tone_phase_s;
        end else begin
            buzzer_d = 1'b1;
        end
    end

    // Scheduler state, counters and registered outputs.
    always_ff @(posedge clk_100mhz or negedge RSTN) begin
        if (!RSTN) begin
            state_q   <= IDLE;
            pending_q <= '0;
            cur_q     <= '0;
            tick_q    <= '0;
            dur_q     <= '0;
            buzzer_q  <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            cur_q     <= cur_d;
            tick_q    <= tick_d;
            dur_q     <= dur_d;
            buzzer_q  <= buzzer_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign Buzzer   = buzzer_q;
    assign busy     = busy_q;
    assign sfx_cur  = cur_q;
    assign sfx_done = done_q;

endmodule

// File: doc/sfx_sched.md
# sfx_sched

Sound-effect scheduler that shares the single board buzzer (`Buzzer`, currently tied inactive at top level) between game events. GameLoop raises one-cycle requests for move, shoot, hit and game-over. The block arbitrates them by fixed priority with preemption, queues one pending request per effect, and drives a square-wave tone of the selected pitch and duration. It sits between GameLoop and the `Buzzer` pin, clocked by `clk_100mhz`.

## Interface
- `TICK_DIV`, default 100000: clocks per millisecond tick. Must be ≥ 2.
- `TONE_SHIFT`, default 0: tone half-period is the table value right-shifted by this amount, clamped to a minimum of 1. Used for simulation speed-up.
- `clk_100mhz`  in  1  system clock.
- `RSTN`  in  1  reset, asynchronous, active-low.
- `sfx_req`  in  4  single-cycle request pulses. Bit 0 move, bit 1 shoot, bit 2 hit, bit 3 game-over. A higher index has higher priority.
- `mute`  in  1  level input. While 1, `Buzzer` is held at 1 and sequencing continues unchanged.
- `Buzzer`  out  1  registered, active-low drive. 1 means silent.
- `busy`  out  1  is 1 in LOAD or PLAY.
- `sfx_cur`  out  2  index of the effect loaded or playing. Holds its last value in IDLE.
- `sfx_done`  out  1  one-cycle pulse when an effect completes its full duration.

## Operation
- Reset values: `Buzzer`=1, `busy`=0, `sfx_cur`=0, `sfx_done`=0. Internally, `pending`=0 and state is IDLE. All counters are 0.
- Pending register (4 bits):
  - Each asserted `sfx_req` bit sets its pending bit. A request for an effect whose pending bit is already set merges into it.
  - If a set and a clear of the same bit happen in the same cycle, the set wins.
- IDLE:
  - `Buzzer`=1.
  - If `pending`≠0, move to LOAD with `sfx_cur` = highest set index, and clear that pending bit.
- LOAD (one cycle):
  - Tone counter = half−1, phase = 0.
  - Tick counter = 0.
  - Duration counter = table duration in ms.
- PLAY:
  - Tone counter counts down. At 0 it reloads half−1 and toggles phase.
  - `Buzzer` = phase, or 1 if `mute`. Phase 0 drives the buzzer low, so each half-period starts with a low level.
  - Tick counter counts 0..`TICK_DIV`−1 and wraps. On wrap the duration counter decrements.
  - When a decrement reaches 0: pulse `sfx_done`, go to IDLE, `Buzzer`=1.
- Preemption: in PLAY, if any pending index is greater than `sfx_cur`, go to LOAD with the highest such index and clear its bit.
  - The preempted effect is dropped and is not resumed.
  - No `sfx_done` pulse is issued for it.
- Lower- or equal-priority requests arriving during PLAY stay pending and are served afterwards in priority order.
- Effect table (half-period in clocks, duration in ms):
  - move: 50000, 20.
  - shoot: 25000, 60.
  - hit: 100000, 150.
  - game-over: 200000, 600.
- Widths: half-period 18 bits unsigned, duration 10 bits, tick counter ceil(log2(`TICK_DIV`)) bits. No signed arithmetic anywhere.

## Timing
- Request pulse sampled at edge t:
  - Pending bit set at t.
  - LOAD at t+1.
  - PLAY from t+2. The first PLAY cycle drives `Buzzer`=0 (unless muted).
- PLAY lasts exactly duration×`TICK_DIV` cycles when not preempted. `sfx_done` is high for the cycle after the last PLAY cycle, which is the first IDLE cycle.
- Back-to-back effects: the IDLE→LOAD→PLAY sequence costs 2 cycles of `Buzzer`=1 between effects.
- Preemption: the request at edge t reaches LOAD at t+1. The new tone starts at t+2 with phase reset to 0.
- Reset asserted mid-effect: all registers return to their reset values immediately, including asynchronously clearing `Buzzer` to 1. Pending requests are lost.

## Structure
- Package `sfx_pkg` holds:
  - state enum {IDLE, LOAD, PLAY};
  - index constants `SFX_MOVE`/`SFX_SHOOT`/`SFX_HIT`/`SFX_OVER`;
  - half-period and duration lookup functions indexed by 2-bit id;
  - width constants.
- One sub-module `tone_gen`: the reloadable half-period down-counter with phase toggle. It has load and enable inputs and a phase output.
- Priority encoder, pending register, tick counter and duration counter stay in `sfx_sched`.

## Test plan
Bench uses `TICK_DIV`=10 and `TONE_SHIFT`=10, giving half-periods 48, 24, 97 and 195.
- Shoot pulse from idle:
  - `busy` rises at t+1 and `Buzzer` goes 0 at t+2.
  - `Buzzer` toggles every 24 cycles.
  - `sfx_done` pulses after 600 PLAY cycles, then `busy`=0 and `Buzzer`=1.
- Move, shoot and hit pulsed in the same cycle:
  - Played in order hit, shoot, move, each for its full duration (1500, 600, 200 cycles).
  - Three `sfx_done` pulses, with 2 silent cycles between effects.
- Move playing, game-over pulsed 50 cycles in:
  - LOAD on the next cycle, `sfx_cur`=3, no `sfx_done` for move.
  - Game-over plays for 6000 cycles and move is not resumed.
- Hit playing, shoot pulsed three times:
  - Shoot plays exactly once after hit completes (requests merge).
- `mute`=1 during a shoot:
  - `Buzzer` stays 1 throughout.
  - `busy` and `sfx_done` timing are identical to the unmuted case.
- `RSTN` low mid-effect with pending bits set:
  - `Buzzer`=1, `busy`=0, `sfx_cur`=0 immediately.
  - Nothing plays after reset is released.
